keypad_scan_ctrl: RTL and testbench
===================================

Name: keypad_scan_ctrl

Overview:
Scan controller for the 4x4 piano keypad. It sequences row strobes, samples the active-low columns after a settle window and debounces each of the 16 keys. It publishes a stable key map plus a queue of press/release events. Game logic consumes the events through a valid/ready handshake instead of polling raw pad levels.

Parameters:
SCAN_DIV, 500000, clock cycles per row slot (10 ms at 50 MHz); must be >= SETTLE+6
SETTLE, 64, cycles from slot start to column sample; must be >= 3 to cover the 2-FF synchroniser
DEBOUNCE_SCANS, 3, consecutive disagreeing samples needed to flip a key; range 1..3
FIFO_DEPTH, 4, event queue entries; power of two

Ports:
CLOCK_50  input  1  system clock
reset  input  1  asynchronous, active-high reset
cols  input  4  keypad columns, active low, pulled up, asynchronous
rows  inout  4  row strobes; active row driven 0, others high-Z
pad  output  16  debounced key map; 1 = pressed
ev_valid  output  1  event queue non-empty
ev_ready  input  1  consumer accepts the head event
ev_key  output  4  key id of the head event
ev_press  output  1  head event: 1 = press, 0 = release
overflow  output  1  sticky: an event was dropped
clr_overflow  input  1  clears overflow

Behaviour:
- Reset (async, immediate, also mid-slot): rows all Z, row index 0, slot counter 0, pad 0, all debounce counters 0, FIFO empty, overflow 0, synchroniser flops 4'b1111.
- Key mapping: row r, column j pressed (rows[r]=0 and cols[j]=0) gives key id k = 4r+j, mapped to pad[15-k].
- cols passes through a 2-FF synchroniser; all logic uses the synchronised value.
- Slot counter sc counts 0..SCAN_DIV-1, then wraps to 0 and row index advances 0→1→2→3→0.
- rows[r] is driven 0 for the whole slot of row r, from the first cycle after reset release; all other rows are Z.
- FSM per slot:
  - SETTLE_WAIT: sc < SETTLE.
  - SAMPLE: sc == SETTLE; capture ~cols_sync and run debounce for the 4 keys of the row.
  - EMIT: sc = SETTLE+1..SETTLE+4; column j is handled at sc = SETTLE+1+j.
  - IDLE: rest of the slot.
- Debounce, per key, 2-bit counter c, in SAMPLE:
  - raw == pad bit: c ← 0.
  - Otherwise, if c+1 == DEBOUNCE_SCANS: flip the pad bit, c ← 0, set pending[j].
  - Otherwise: c ← c+1.
- Flip timing: a pad bit changes on the cycle after SAMPLE. An unchanged sample in any scan resets the counter.
- EMIT:
  - For column j with pending[j] set, push {new pad value, k} to the FIFO, then clear pending[j].
  - Multiple changes in one row come out in ascending column order, one per cycle.
- FIFO:
  - Outputs: ev_valid = !empty; ev_key/ev_press reflect the head.
  - Pop: on ev_valid & ev_ready. A pushed entry is visible on the next cycle.
  - Full, push without pop: the event is dropped and overflow is set; pad is still updated.
  - Full with simultaneous push and pop: both are accepted, occupancy unchanged, no overflow.
  - Empty with push and ev_ready high: the entry is not popped the same cycle (no bypass).
- overflow:
  - clr_overflow clears it.
  - A drop in the same cycle as clr_overflow leaves overflow = 1.
- Released keypad: sampled value is 0, so the reset state generates no events.

Test Plan:
All scenarios use SCAN_DIV=16, SETTLE=4, DEBOUNCE_SCANS=3, FIFO_DEPTH=4; one full scan = 64 cycles.
- Reset:
  - Stimulus: assert reset mid-slot 2 with cols=4'b0000.
  - Required: rows=ZZZZ, pad=0, ev_valid=0 immediately.
  - After release: rows[0]=0 with others Z for 16 cycles, then rows[1]=0.
- Press key 5 (cols[1]=0 while rows[1]=0), held:
  - No change after the 1st or 2nd samples.
  - After the 3rd sample: pad=16'h0400.
  - One event ev_key=5, ev_press=1; pops with ev_ready=1.
- Glitch:
  - Key 5 held for exactly 2 scans, then released.
  - Required: pad stays 0, ev_valid never asserts.
- Release:
  - After the press scenario, release key 5 for 3 scans.
  - Required: pad=0 and one event {press=0, key=5}.
- Same-row simultaneous change:
  - Keys 0 and 3 pressed together.
  - Required: pad=16'h9000 after debounce; events key 0 then key 3 on consecutive cycles.
- Overflow:
  - ev_ready=0; generate 5 events (press 0,1,2,3 then release 0).
  - Required: queue holds keys 0,1,2,3 in order; overflow=1; pad=16'h7000.
  - clr_overflow pulse → overflow=0.
  - A full-queue push+pop in the same cycle keeps occupancy 4 and overflow 0.

Source files
------------

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: strobes one row per slot, samples synchronised columns after a settle
// window, debounces all 16 keys and queues press/release events behind a valid/ready port.
module keypad_scan_ctrl #(
  parameter int unsigned SCAN_DIV       = 500000,
  parameter int unsigned SETTLE         = 64,
  parameter int unsigned DEBOUNCE_SCANS = 3,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [3:0]  cols,
  inout  wire  [3:0]  rows,
  output logic [15:0] pad,
  output logic        ev_valid,
  input  logic        ev_ready,
  output logic [3:0]  ev_key,
  output logic        ev_press,
  output logic        overflow,
  input  logic        clr_overflow
);

  localparam int unsigned ScW  = $clog2(SCAN_DIV);
  localparam int unsigned Aw   = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = Aw + 1;

  localparam logic [ScW-1:0]  ScLast      = ScW'(SCAN_DIV - 1);
  localparam logic [ScW-1:0]  ScSample    = ScW'(SETTLE);
  localparam logic [ScW-1:0]  ScEmitBase  = ScW'(SETTLE + 1);
  localparam logic [ScW-1:0]  ScEmitLast  = ScW'(SETTLE + 4);
  localparam logic [2:0]      DbTarget    = 3'(DEBOUNCE_SCANS);
  localparam logic [CntW-1:0] FifoFull    = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    StSettle,
    StSample,
    StEmit,
    StIdle
  } state_e;

  // Column synchroniser, idles high to match the pulled-up released pad.
  logic [3:0] sync1_q, sync2_q;

  logic [ScW-1:0] sc_q, sc_d;
  logic [1:0]     row_q, row_d;
  state_e         state_q, state_d;

  logic [15:0]      pad_q, pad_d;
  logic [15:0][1:0] cnt_q, cnt_d;
  logic [3:0]       pending_q, pending_d;

  logic [4:0]      mem_q [FIFO_DEPTH];
  logic [Aw-1:0]   wr_ptr_q, wr_ptr_d;
  logic [Aw-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            overflow_q, overflow_d;

  logic       do_sample;
  logic       do_emit;
  logic [1:0] emit_col;
  logic       push_req;
  logic [4:0] push_data;
  logic       pop;
  logic       full;
  logic       push_ok;
  logic       drop;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sync1_q <= 4'b1111;
      sync2_q <= 4'b1111;
    end else begin
      sync1_q <= cols;
      sync2_q <= sync1_q;
    end
  end

  // FSM: state register
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sc_q    <= '0;
      row_q   <= 2'd0;
      state_q <= StSettle;
    end else begin
      sc_q    <= sc_d;
      row_q   <= row_d;
      state_q <= state_d;
    end
  end

  // FSM: next state follows the slot counter so state_q always describes sc_q
  always_comb begin
    sc_d  = sc_q + 1'b1;
    row_d = row_q;
    if (sc_q == ScLast) begin
      sc_d  = '0;
      row_d = row_q + 2'd1;
    end
    if (sc_d < ScSample) begin
      state_d = StSettle;
    end else if (sc_d == ScSample) begin
      state_d = StSample;
    end else if (sc_d <= ScEmitLast) begin
      state_d = StEmit;
    end else begin
      state_d = StIdle;
    end
  end

  // FSM: outputs
  always_comb begin
    do_sample = 1'b0;
    do_emit   = 1'b0;
    emit_col  = 2'(sc_q - ScEmitBase);
    unique case (state_q)
      StSample: do_sample = 1'b1;
      StEmit:   do_emit   = 1'b1;
      StSettle,
      StIdle:   ;
      default:  ;
    endcase
  end

  for (genvar r = 0; r < 4; r++) begin : g_rows
    assign rows[r] = (!reset && (row_q == 2'(r))) ? 1'b0 : 1'bz;
  end

  // Debounce on SAMPLE, event generation on EMIT (one column per cycle)
  always_comb begin
    logic [3:0] k;
    logic [2:0] cnt_inc;
    logic       raw;
    pad_d     = pad_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    push_req  = 1'b0;
    push_data = 5'd0;
    k         = 4'd0;
    cnt_inc   = 3'd0;
    raw       = 1'b0;
    if (do_sample) begin
      for (int j = 0; j < 4; j++) begin
        k       = {row_q, 2'(j)};
        raw     = ~sync2_q[j];
        cnt_inc = {1'b0, cnt_q[k]} + 3'd1;
        if (raw == pad_q[~k]) begin
          cnt_d[k] = 2'd0;
        end else if (cnt_inc == DbTarget) begin
          pad_d[~k]    = raw;
          cnt_d[k]     = 2'd0;
          pending_d[j] = 1'b1;
        end else begin
          cnt_d[k] = cnt_inc[1:0];
        end
      end
    end
    if (do_emit && pending_q[emit_col]) begin
      k                   = {row_q, emit_col};
      push_req            = 1'b1;
      push_data           = {pad_q[~k], k};
      pending_d[emit_col] = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      pad_q     <= '0;
      cnt_q     <= '0;
      pending_q <= '0;
    end else begin
      pad_q     <= pad_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
    end
  end

  // Event FIFO; a full queue still accepts a push when the head leaves the same cycle.
  always_comb begin
    pop      = (count_q != '0) && ev_ready;
    full     = (count_q == FifoFull);
    push_ok  = push_req && (!full || pop);
    drop     = push_req && full && !pop;
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push_ok && pop) begin
      count_d = count_q - 1'b1;
    end
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_comb begin
    pad      = pad_q;
    ev_valid = (count_q != '0);
    ev_press = mem_q[rd_ptr_q][4];
    ev_key   = mem_q[rd_ptr_q][3:0];
    overflow = overflow_q;
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl: a keypad model drives cols from rows, and expected
// events go into a scoreboard queue that is checked as the DUT hands them out.
module tb_keypad_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  wire  [3:0]  cols;
  wire  [3:0]  rows;
  logic [15:0] pad;
  logic        ev_valid;
  logic        ev_ready;
  logic [3:0]  ev_key;
  logic        ev_press;
  logic        overflow;
  logic        clr_overflow;

  logic [15:0] keys;
  logic        force_low;
  logic [3:0]  keypad_cols;
  int          cyc;
  int          checks = 0;
  int          failures = 0;
  logic [4:0]  sb[$];

  pullup pu_r0 (rows[0]);
  pullup pu_r1 (rows[1]);
  pullup pu_r2 (rows[2]);
  pullup pu_r3 (rows[3]);

  keypad_scan_ctrl #(
    .SCAN_DIV      (16),
    .SETTLE        (4),
    .DEBOUNCE_SCANS(3),
    .FIFO_DEPTH    (4)
  ) dut (
    .CLOCK_50    (clk),
    .reset       (reset),
    .cols        (cols),
    .rows        (rows),
    .pad         (pad),
    .ev_valid    (ev_valid),
    .ev_ready    (ev_ready),
    .ev_key      (ev_key),
    .ev_press    (ev_press),
    .overflow    (overflow),
    .clr_overflow(clr_overflow)
  );

  always #5 clk = ~clk;

  // Passive keypad: a held key shorts its column to a row being pulled low.
  always_comb begin
    keypad_cols = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 4; j++) begin
        if (rows[r] === 1'b0 && keys[4*r+j]) keypad_cols[j] = 1'b0;
      end
    end
  end
  assign cols = force_low ? 4'b0000 : keypad_cols;

  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int r, input int s);
    int t = 0;
    while ((cyc % 64) != (r * 16 + s) && t < 70) begin
      tick();
      t++;
    end
  endtask

  task automatic next_at(input int r, input int s);
    tick();
    goto(r, s);
  endtask

  task automatic cmp_head(input string tag);
    logic [4:0] exp;
    if (sb.size() == 0) begin
      check({tag, " scoreboard_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      exp = sb.pop_front();
      check(tag, {27'd0, ev_press, ev_key}, {27'd0, exp});
    end
  endtask

  task automatic pop_one(input string tag);
    int t = 0;
    while (!ev_valid && t < 200) begin
      tick();
      t++;
    end
    check({tag, " valid"}, ev_valid, 1'b1);
    if (ev_valid) begin
      cmp_head(tag);
      ev_ready = 1'b1;
      tick();
      ev_ready = 1'b0;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen_valid;
    bit pad_moved;
    reset        = 1'b1;
    ev_ready     = 1'b0;
    clr_overflow = 1'b0;
    keys         = 16'h0;
    force_low    = 1'b0;

    // Reset state and row strobe sequence after release
    tick();
    tick();
    check("rst rows", rows, 4'b1111);
    check("rst pad", pad, 16'h0);
    check("rst valid", ev_valid, 1'b0);
    check("rst overflow", overflow, 1'b0);
    reset = 1'b0;
    #1;
    check("row0 first", rows, 4'b1110);
    for (int i = 1; i < 16; i++) begin
      tick();
      check("row0 hold", rows, 4'b1110);
    end
    tick();
    check("row1 start", rows, 4'b1101);

    // Press key 5 (row 1, col 1)
    next_at(1, 10);
    keys[5] = 1'b1;
    next_at(1, 5);
    check("press s1 pad", pad, 16'h0);
    next_at(1, 5);
    check("press s2 pad", pad, 16'h0);
    sb.push_back({1'b1, 4'd5});
    next_at(1, 5);
    check("press s3 pad", pad, 16'h0400);
    check("press no bypass", ev_valid, 1'b0);
    next_at(1, 7);
    check("press valid", ev_valid, 1'b1);
    pop_one("press5 event");
    check("press drained", ev_valid, 1'b0);

    // Release key 5
    next_at(1, 10);
    keys[5] = 1'b0;
    next_at(1, 5);
    next_at(1, 5);
    check("release s2 pad", pad, 16'h0400);
    sb.push_back({1'b0, 4'd5});
    next_at(1, 5);
    check("release s3 pad", pad, 16'h0);
    pop_one("release5 event");

    // Glitch: two disagreeing samples, then agreement
    next_at(1, 10);
    keys[5] = 1'b1;
    next_at(1, 5);
    next_at(1, 5);
    keys[5] = 1'b0;
    seen_valid = 1'b0;
    pad_moved  = 1'b0;
    for (int i = 0; i < 256; i++) begin
      tick();
      if (ev_valid) seen_valid = 1'b1;
      if (pad != 16'h0) pad_moved = 1'b1;
    end
    check("glitch valid", seen_valid, 1'b0);
    check("glitch pad", pad_moved, 1'b0);

    // Keys 0 and 3 change in the same row sample
    next_at(0, 10);
    keys[0] = 1'b1;
    keys[3] = 1'b1;
    next_at(0, 5);
    next_at(0, 5);
    sb.push_back({1'b1, 4'd0});
    sb.push_back({1'b1, 4'd3});
    next_at(0, 5);
    check("row pair pad", pad, 16'h9000);
    next_at(0, 9);
    ev_ready = 1'b1;
    check("row pair first valid", ev_valid, 1'b1);
    cmp_head("row pair first");
    tick();
    check("row pair second valid", ev_valid, 1'b1);
    cmp_head("row pair second");
    tick();
    ev_ready = 1'b0;
    check("row pair drained", ev_valid, 1'b0);

    next_at(0, 10);
    keys = 16'h0;
    next_at(0, 5);
    next_at(0, 5);
    sb.push_back({1'b0, 4'd0});
    sb.push_back({1'b0, 4'd3});
    next_at(0, 5);
    check("row pair release pad", pad, 16'h0);
    pop_one("row pair rel0");
    pop_one("row pair rel3");

    // Overflow: four presses fill the queue, the release of key 0 is dropped
    next_at(0, 10);
    keys[3:0] = 4'hF;
    next_at(0, 5);
    next_at(0, 5);
    for (int k = 0; k < 4; k++) sb.push_back({1'b1, 4'(k)});
    next_at(0, 5);
    check("ovf press pad", pad, 16'hF000);
    next_at(0, 10);
    check("ovf queue valid", ev_valid, 1'b1);
    check("ovf before drop", overflow, 1'b0);
    keys[0] = 1'b0;
    next_at(0, 5);
    next_at(0, 5);
    next_at(0, 5);
    check("ovf release pad", pad, 16'h7000);
    check("ovf not yet", overflow, 1'b0);
    tick();
    check("ovf set", overflow, 1'b1);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    check("ovf cleared", overflow, 1'b0);

    // Full queue: push and pop on the same edge
    keys[0] = 1'b1;
    next_at(0, 5);
    next_at(0, 5);
    next_at(0, 5);
    check("full pushpop pad", pad, 16'hF000);
    ev_ready = 1'b1;
    cmp_head("full pushpop head");
    sb.push_back({1'b1, 4'd0});
    tick();
    ev_ready = 1'b0;
    check("full pushpop overflow", overflow, 1'b0);
    pop_one("full drain 1");
    pop_one("full drain 2");
    pop_one("full drain 3");
    check("full last valid", ev_valid, 1'b1);
    check("full last key", {ev_press, ev_key}, {1'b1, 4'd0});

    // Asynchronous reset mid-slot of row 2 with every column pulled low
    goto(2, 8);
    check("pre rst pad", pad, 16'hF000);
    force_low = 1'b1;
    reset     = 1'b1;
    #1;
    check("mid rst rows", rows, 4'b1111);
    check("mid rst pad", pad, 16'h0);
    check("mid rst valid", ev_valid, 1'b0);
    check("mid rst overflow", overflow, 1'b0);
    sb.delete();
    keys = 16'h0;
    tick();
    force_low = 1'b0;
    reset     = 1'b0;
    #1;
    check("post rst row0", rows, 4'b1110);
    for (int i = 0; i < 16; i++) tick();
    check("post rst row1", rows, 4'b1101);
    check("post rst pad", pad, 16'h0);
    check("post rst valid", ev_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
